// File: rtl/rca_pipe_addsub_pkg.sv
// rtl/rca_pipe_addsub_pkg.sv - shared defaults and mode encoding for the pipelined add/sub unit
package rca_pipe_addsub_pkg;

  localparam int DEFAULT_WIDTH  = 16;
  localparam int DEFAULT_STAGES = 4;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

  // Subtraction is a + ~b + 1, so the external carry-in only matters when adding.
  function automatic logic stage0_cin(input mode_e mode, input logic cin);
    return (mode == MODE_SUB) ? 1'b1 : cin;
  endfunction

endpackage

// File: rtl/rca_pipe_addsub_if.sv
// rtl/rca_pipe_addsub_if.sv - operand/result handshake bundle for rca_pipe_addsub
interface rca_pipe_addsub_if
  import rca_pipe_addsub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );

endinterface

// File: rtl/rca_pipe_addsub_slice.sv
// rtl/rca_pipe_addsub_slice.sv - SW-bit combinational ripple chain of full-adder cells
module rca_pipe_addsub_slice
  import rca_pipe_addsub_pkg::*;
#(
  parameter int SW = DEFAULT_WIDTH / DEFAULT_STAGES
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          cin,
  output logic [SW-1:0] s,
  output logic          cout
);

  logic [SW:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < SW; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[SW];

endmodule

// File: rtl/rca_pipe_addsub.sv
// rtl/rca_pipe_addsub.sv - pipelined ripple-carry add/subtract, one SW-bit slice per stage
// Global stall: when the last stage holds an unaccepted result, every stage freezes.
module rca_pipe_addsub
  import rca_pipe_addsub_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic              clk,
  input  logic              rst,
  rca_pipe_addsub_if.slave  bus
);

  localparam int SW   = WIDTH / STAGES;
  localparam int MSB  = WIDTH - 1;
  localparam int LAST = STAGES - 1;

  logic             stall;
  mode_e            mode;

  // Stage inputs: stage 0 from the bus, stage k from the registers of stage k-1.
  logic             v_in    [STAGES];
  logic             c_in    [STAGES];
  logic [WIDTH-1:0] a_in    [STAGES];
  logic [WIDTH-1:0] bp_in   [STAGES];
  logic [WIDTH-1:0] s_in    [STAGES];

  logic [SW-1:0]    s_slice [STAGES];
  logic             c_slice [STAGES];
  logic [WIDTH-1:0] s_merge [STAGES];

  logic             valid_d [STAGES];
  logic             valid_q [STAGES];
  logic             carry_d [STAGES];
  logic             carry_q [STAGES];
  logic [WIDTH-1:0] a_d     [STAGES];
  logic [WIDTH-1:0] a_q     [STAGES];
  logic [WIDTH-1:0] bp_d    [STAGES];
  logic [WIDTH-1:0] bp_q    [STAGES];
  logic [WIDTH-1:0] s_d     [STAGES];
  logic [WIDTH-1:0] s_q     [STAGES];
  logic             zero_d;
  logic             zero_q;

  assign mode  = mode_e'(bus.sub);
  assign stall = valid_q[LAST] & ~bus.out_ready;

  always_comb begin
    v_in[0]  = bus.in_valid;
    a_in[0]  = bus.a;
    bp_in[0] = (mode == MODE_SUB) ? ~bus.b : bus.b;
    c_in[0]  = stage0_cin(mode, bus.cin);
    s_in[0]  = '0;
    for (int k = 1; k < STAGES; k++) begin
      v_in[k]  = valid_q[k-1];
      a_in[k]  = a_q[k-1];
      bp_in[k] = bp_q[k-1];
      c_in[k]  = carry_q[k-1];
      s_in[k]  = s_q[k-1];
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    rca_pipe_addsub_slice #(
      .SW (SW)
    ) u_slice (
      .a    (a_in[g][g*SW +: SW]),
      .b    (bp_in[g][g*SW +: SW]),
      .cin  (c_in[g]),
      .s    (s_slice[g]),
      .cout (c_slice[g])
    );
  end

  // Bubbles advance like real beats so the pipe never collapses or reorders.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      s_merge[k]              = s_in[k];
      s_merge[k][k*SW +: SW]  = s_slice[k];
      valid_d[k] = stall ? valid_q[k] : v_in[k];
      carry_d[k] = stall ? carry_q[k] : c_slice[k];
      a_d[k]     = stall ? a_q[k]     : a_in[k];
      bp_d[k]    = stall ? bp_q[k]    : bp_in[k];
      s_d[k]     = stall ? s_q[k]     : s_merge[k];
    end
    zero_d = stall ? zero_q : (s_merge[LAST] == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        carry_q[k] <= 1'b0;
        a_q[k]     <= '0;
        bp_q[k]    <= '0;
        s_q[k]     <= '0;
      end
      zero_q <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= valid_d[k];
        carry_q[k] <= carry_d[k];
        a_q[k]     <= a_d[k];
        bp_q[k]    <= bp_d[k];
        s_q[k]     <= s_d[k];
      end
      zero_q <= zero_d;
    end
  end

  assign bus.in_ready  = ~stall;
  assign bus.out_valid = valid_q[LAST];
  assign bus.sum       = s_q[LAST];
  assign bus.cout      = carry_q[LAST];
  assign bus.zero      = zero_q;
  // Operand sign bits ride to the last stage; all-zero registers after reset keep ovf low.
  assign bus.ovf       = (a_q[LAST][MSB] == bp_q[LAST][MSB]) & (s_q[LAST][MSB] != a_q[LAST][MSB]);

endmodule

// File: tb/tb_rca_pipe_addsub.sv
// tb/tb_rca_pipe_addsub.sv - directed and streaming checks for rca_pipe_addsub (WIDTH=16, STAGES=4)
module tb_rca_pipe_addsub;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  rca_pipe_addsub_if #(.WIDTH(16)) bus ();

  rca_pipe_addsub #(
    .WIDTH  (16),
    .STAGES (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic cin, input logic sub);
    logic [15:0] bp;
    logic [16:0] r;
    logic        ov;
    bp = sub ? ~b : b;
    r  = {1'b0, a} + {1'b0, bp} + {16'd0, (sub ? 1'b1 : cin)};
    ov = (a[15] == bp[15]) && (r[15] != a[15]);
    return {r[15:0], r[16], ov, (r[15:0] == 16'd0)};
  endfunction

  // One isolated beat: accept it, count edges until out_valid, then compare the result.
  task automatic run_vec(input vec_t v, input string name);
    int n;
    bit found;
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.a = v.a; bus.b = v.b; bus.cin = v.cin; bus.sub = v.sub;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    n = 0;
    found = 0;
    while (!found && n < 12) begin
      @(negedge clk);
      n++;
      if (bus.out_valid) found = 1;
    end
    check({name, "_latency"}, n, 4);
    check({name, "_sum"}, bus.sum, v.sum);
    check({name, "_flags"}, {bus.cout, bus.ovf, bus.zero}, {v.cout, v.ovf, v.zero});
  endtask

  vec_t        vecs [8];
  logic [15:0] sa [8];
  logic [15:0] sb [8];
  logic        sc [8];
  logic        ss [8];
  logic [18:0] exp_q [$];
  logic [18:0] e;

  initial begin
    int sent, got, cyc;
    bit stale;

    checks = 0;
    failures = 0;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{16'h0010, 16'h0010, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
    #2;
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_outputs", {bus.sum, bus.cout, bus.ovf, bus.zero}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 check("reset_in_ready", bus.in_ready, 1);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 8; i++) begin
      sa[i] = 16'($urandom);
      sb[i] = 16'($urandom);
      sc[i] = 1'($urandom_range(0, 1));
      ss[i] = 1'($urandom_range(0, 1));
    end
    sent = 0; got = 0; cyc = 0;
    while (got < 8 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      bus.out_ready = 1'($urandom_range(0, 1));
      if (sent < 8) begin
        bus.in_valid = 1'b1;
        bus.a = sa[sent]; bus.b = sb[sent]; bus.cin = sc[sent]; bus.sub = ss[sent];
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      check("in_ready_rule", bus.in_ready, !(bus.out_valid && !bus.out_ready));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check($sformatf("stream_beat%0d", got), {bus.sum, bus.cout, bus.ovf, bus.zero}, e);
        end else begin
          check("stream_unexpected", 1, 0);
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(sa[sent], sb[sent], sc[sent], ss[sent]));
        sent++;
      end
    end
    check("stream_count", got, 8);
    check("stream_leftover", exp_q.size(), 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid) stale = 1;
    end
    check("stream_duplicate", stale, 0);

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a = 16'h1111 * 16'(i + 1); bus.b = 16'h0101; bus.cin = 1'b0; bus.sub = 1'b0;
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("midreset_out_valid", bus.out_valid, 0);
    check("midreset_outputs", {bus.sum, bus.cout, bus.ovf, bus.zero}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.out_valid) stale = 1;
    end
    check("midreset_no_stale", stale, 0);
    run_vec(vecs[0], "post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
